// File: rtl/monitor_contador16_pkg.sv
// -----------------------------------------------------------------------------
// monitor_contador16_pkg
// Shared widths, counter mode encodings and monitor FSM states used by the
// 16-bit counter monitor and its combinational reference model.
// -----------------------------------------------------------------------------
package monitor_contador16_pkg;

  localparam int Q_W     = 16;
  localparam int RCO_W   = 4;
  localparam int NIBBLES = Q_W / 4;
  localparam int ERR_W   = 8;
  localparam int WRAP_W  = 16;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    MODO_UP    = 2'b00,
    MODO_DOWN  = 2'b01,
    MODO_DOWN3 = 2'b10,
    MODO_LOAD  = 2'b11
  } modo_t;

  typedef enum logic {
    ST_UNSYNC = 1'b0,
    ST_TRACK  = 1'b1
  } state_t;

endpackage

// File: rtl/monitor_contador16_modelo.sv
// -----------------------------------------------------------------------------
// modelo_contador16
// Purely combinational reference model of the 16-bit counter: given the
// current model value, the mode and the load bus, produce the next value and
// the per-nibble ripple-carry (carry out when counting up, borrow out when
// counting down).
//   q_i        current model value
//   modo_i     counter mode
//   d_i        load value
//   q_next_o   next model value (modulo 2^16)
//   rco_next_o per-nibble carry/borrow of this update (0000 on load)
// -----------------------------------------------------------------------------
module modelo_contador16
  import monitor_contador16_pkg::*;
(
  input  logic [Q_W-1:0]   q_i,
  input  logic [1:0]       modo_i,
  input  logic [Q_W-1:0]   d_i,
  output logic [Q_W-1:0]   q_next_o,
  output logic [RCO_W-1:0] rco_next_o
);

  logic [Q_W-1:0] step;
  logic           up;
  logic           carry;
  logic [4:0]     sum;

  // NOTE: every signal written here gets a default first so no path leaves a
  // value unassigned; that is what keeps always_comb free of inferred latches.
  always_comb begin
    step       = '0;
    up         = 1'b1;
    carry      = 1'b0;
    sum        = '0;
    q_next_o   = q_i;
    rco_next_o = '0;

    unique case (modo_i)
      MODO_UP:    begin step = 16'd1; up = 1'b1; end
      MODO_DOWN:  begin step = 16'd1; up = 1'b0; end
      MODO_DOWN3: begin step = 16'd3; up = 1'b0; end
      default:    begin step = '0;    up = 1'b1; end
    endcase

    if (modo_i == MODO_LOAD) begin
      q_next_o   = d_i;
      rco_next_o = '0;
    end else begin
      // Ripple nibble by nibble so each nibble's carry/borrow is visible.
      // In 5-bit subtraction an underflow leaves bit 4 set, i.e. the borrow.
      for (int i = 0; i < NIBBLES; i++) begin
        if (up) begin
          sum = {1'b0, q_i[4*i +: 4]} + {1'b0, step[4*i +: 4]} + {4'd0, carry};
        end else begin
          sum = {1'b0, q_i[4*i +: 4]} - {1'b0, step[4*i +: 4]} - {4'd0, carry};
        end
        q_next_o[4*i +: 4] = sum[3:0];
        carry              = sum[4];
        rco_next_o[i]      = sum[4];
      end
    end
  end

endmodule

// File: rtl/monitor_contador16.sv
// -----------------------------------------------------------------------------
// monitor_contador16
// Passive monitor for a 16-bit up/down/down-by-3/load counter. It keeps its own
// model of the counter, synchronises on the first load, then flags every cycle
// where the observed Q/RCO disagree with the model.
//   clk, reset         clock, asynchronous active-high reset
//   enb, modo, D       the counter's own control inputs (observed only)
//   Q, RCO             counter outputs under observation
//   synced             model holds a known counter value
//   err                one-cycle pulse per mismatch
//   err_sticky         set on first mismatch, cleared only by reset
//   err_count          saturating mismatch count
//   wrap_count         predicted full wraps (model RCO[3] set), modulo 2^16
// -----------------------------------------------------------------------------
module monitor_contador16
  import monitor_contador16_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic [1:0]        modo,
  input  logic [Q_W-1:0]    D,
  input  logic [Q_W-1:0]    Q,
  input  logic [RCO_W-1:0]  RCO,
  output logic              synced,
  output logic              err,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count
);

  state_t             state_q;
  logic [Q_W-1:0]     q_exp_q;
  logic [RCO_W-1:0]   rco_exp_q;
  logic [Q_W-1:0]     q_exp_d;
  logic [RCO_W-1:0]   rco_exp_d;
  logic               synced_q;
  logic               err_q;
  logic               err_sticky_q;
  logic [ERR_W-1:0]   err_count_q;
  logic [WRAP_W-1:0]  wrap_count_q;
  logic               mismatch;

  modelo_contador16 u_modelo (
    .q_i        (q_exp_q),
    .modo_i     (modo),
    .d_i        (D),
    .q_next_o   (q_exp_d),
    .rco_next_o (rco_exp_d)
  );

  // Current observed outputs against current model contents.
  assign mismatch = (Q != q_exp_q) || (RCO != rco_exp_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, matching the counter it is shadowing.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the model registers are reset too; tracking restarts from a clean
    // UNSYNC state rather than from stale model contents.
    if (reset) begin
      state_q      <= ST_UNSYNC;
      q_exp_q      <= '0;
      rco_exp_q    <= '0;
      synced_q     <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        ST_UNSYNC: begin
          // Count modes carry no information until a known value is loaded.
          if (enb && (modo == MODO_LOAD)) begin
            q_exp_q   <= D;
            rco_exp_q <= '0;
            state_q   <= ST_TRACK;
            synced_q  <= 1'b1;
          end
        end
        ST_TRACK: begin
          if (mismatch) begin
            err_q        <= 1'b1;
            err_sticky_q <= 1'b1;
            if (err_count_q != ERR_MAX) begin
              err_count_q <= err_count_q + 1'b1;
            end
          end
          if (enb) begin
            q_exp_q   <= q_exp_d;
            rco_exp_q <= rco_exp_d;
            if (rco_exp_d[RCO_W-1]) begin
              wrap_count_q <= wrap_count_q + 1'b1;
            end
          end else begin
            rco_exp_q <= '0;
          end
        end
        default: state_q <= ST_UNSYNC;
      endcase
    end
  end

  assign synced     = synced_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;

endmodule
